// File: rtl/led_div_ctrl.sv
// led_div_ctrl
// Pushbutton-driven divider selector feeding led_cnt's div_i / wren_i pair.
// A raw board button is synchronized into clk100 and debounced. Every clean
// press steps the 5-bit divider (wrapping from DIV_MAX to 0) and pulses a
// one-cycle write strobe so led_cnt picks up the new blink rate.
//
// Ports:
//   clk100   in   1  system clock (100 MHz)
//   rst      in   1  asynchronous, active-high reset
//   btn_i    in   1  raw button, active-high, asynchronous, may bounce
//   div_o    out  5  current divider value (to led_cnt.div_i)
//   wren_o   out  1  one-cycle strobe, div_o already valid (to led_cnt.wren_i)
//   btn_db_o out  1  debounced button level (status/debug)
//
// Optional feature macro: LED_DIV_LONGPRESS_EN
//   Defined:   holding the button LONG_CYC cycles after a press restores
//              DIV_INIT with one extra strobe, then nothing until release.
//   Undefined: no long-press counter and no HELD state; LONG_CYC is unused.

module led_div_ctrl #(
  parameter int         DEBOUNCE_CYC = 1_000_000,
  parameter logic [4:0] DIV_INIT     = 5'h2,
  parameter logic [4:0] DIV_MAX      = 5'd31,
  parameter int         LONG_CYC     = 100_000_000
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       btn_i,
  output logic [4:0] div_o,
  output logic       wren_o,
  output logic       btn_db_o
);

  // Width holds the value DEBOUNCE_CYC itself (see the debounce block).
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC);

  // Reject nonsensical parameter sets at elaboration.
  if (DEBOUNCE_CYC < 1) begin : g_badDebounce
    $error("led_div_ctrl: DEBOUNCE_CYC must be at least 1");
  end
  if (LONG_CYC < 1) begin : g_badLong
    $error("led_div_ctrl: LONG_CYC must be at least 1");
  end
  if (DIV_INIT > DIV_MAX) begin : g_badInit
    $error("led_div_ctrl: DIV_INIT must not exceed DIV_MAX");
  end

`ifdef LED_DIV_LONGPRESS_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  localparam int LW = $clog2(LONG_CYC + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);

  logic [LW-1:0] r_longCnt;
  logic [LW-1:0] w_longNext;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1
  } state_t;
`endif

  logic          r_btnMeta;
  logic          r_btnSync;
  logic          r_btnDb;
  logic [DW-1:0] r_dbCnt;

  state_t        r_state;
  state_t        w_stateNext;
  logic [4:0]    r_div;
  logic [4:0]    w_divNext;
  logic          r_wren;
  logic          w_wrenNext;

  // Two-flop synchronizer plus debounce. The counter must climb all the way
  // to DEBOUNCE_CYC while the mismatch persists, so a level change is only
  // accepted after DEBOUNCE_CYC+1 consecutive disagreeing samples; this puts
  // the debounced edge DEBOUNCE_CYC+2 clocks after the first clock that sees
  // the raw level, and any shorter glitch is discarded when the counter
  // clears on the first agreeing sample.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_btnMeta <= 1'b0;
      r_btnSync <= 1'b0;
      r_btnDb   <= 1'b0;
      r_dbCnt   <= '0;
    end else begin
      r_btnMeta <= btn_i;
      r_btnSync <= r_btnMeta;
      if (r_btnSync == r_btnDb) begin
        r_dbCnt <= '0;
      end else if (r_dbCnt == DB_LAST) begin
        r_btnDb <= r_btnSync;
        r_dbCnt <= '0;
      end else begin
        r_dbCnt <= r_dbCnt + DW'(1);
      end
    end
  end

  // Press FSM state, divider and strobe registers; all outputs come straight
  // from these flops so nothing combinational reaches the ports.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_div     <= DIV_INIT;
      r_wren    <= 1'b0;
`ifdef LED_DIV_LONGPRESS_EN
      r_longCnt <= '0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_div     <= w_divNext;
      r_wren    <= w_wrenNext;
`ifdef LED_DIV_LONGPRESS_EN
      r_longCnt <= w_longNext;
`endif
    end
  end

  // Next-state logic. The divider only ever moves in the same branch that
  // raises the strobe, so div_o and wren_o stay in lockstep. A release seen
  // on the same clock as the long-press expiry takes priority.
  always_comb begin
    w_stateNext = r_state;
    w_divNext   = r_div;
    w_wrenNext  = 1'b0;
`ifdef LED_DIV_LONGPRESS_EN
    w_longNext  = r_longCnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_btnDb) begin
          w_stateNext = ST_PRESSED;
          w_divNext   = (r_div == DIV_MAX) ? 5'd0 : r_div + 5'd1;
          w_wrenNext  = 1'b1;
`ifdef LED_DIV_LONGPRESS_EN
          w_longNext  = '0;
`endif
        end
      end
      ST_PRESSED: begin
        if (!r_btnDb) begin
          w_stateNext = ST_IDLE;
        end
`ifdef LED_DIV_LONGPRESS_EN
        else if (r_longCnt == LONG_LAST) begin
          w_stateNext = ST_HELD;
          w_divNext   = DIV_INIT;
          w_wrenNext  = 1'b1;
        end else begin
          w_longNext  = r_longCnt + LW'(1);
        end
`endif
      end
`ifdef LED_DIV_LONGPRESS_EN
      ST_HELD: begin
        if (!r_btnDb) begin
          w_stateNext = ST_IDLE;
        end
      end
`endif
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign div_o    = r_div;
  assign wren_o   = r_wren;
  assign btn_db_o = r_btnDb;

endmodule

// File: tb/tb_led_div_ctrl.sv
// tb_led_div_ctrl
// Randomized, self-checking bench for led_div_ctrl with DEBOUNCE_CYC=4 and
// LONG_CYC=20. A behavioural reference model tracks the raw button history
// and derives the expected debounced level, divider and strobe from the
// press rules; scenario tasks compare the DUT against it every cycle and
// also check the fixed latencies and totals directly.

module tb_led_div_ctrl;

  localparam int         DB_CYC   = 4;
  localparam int         LONG_CYC = 20;
  localparam logic [4:0] DIV_INIT = 5'd2;
  localparam logic [4:0] DIV_MAX  = 5'd31;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b1;
  logic       btn_i  = 1'b0;
  logic [4:0] div_o;
  logic       wren_o;
  logic       btn_db_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0] mDiv      = DIV_INIT;
  logic       mWren     = 1'b0;
  logic       mDb       = 1'b0;
  logic       hist[$];
  int         mRun      = 0;
  int         mEnter    = 0;
  bit         mInPress  = 1'b0;
  bit         mLongDone = 1'b0;

  led_div_ctrl #(
    .DEBOUNCE_CYC(DB_CYC),
    .DIV_INIT    (DIV_INIT),
    .DIV_MAX     (DIV_MAX),
    .LONG_CYC    (LONG_CYC)
  ) dut (
    .clk100  (clk100),
    .rst     (rst),
    .btn_i   (btn_i),
    .div_o   (div_o),
    .wren_o  (wren_o),
    .btn_db_o(btn_db_o)
  );

  always #5 clk100 = ~clk100;

  // Reference model. The raw sample taken at clock n becomes visible to the
  // debouncer two clocks later; the debounced level flips once DB_CYC+1
  // consecutive visible samples disagree with it. A press is acted on one
  // clock after the debounced level is high, and a long press fires LONG_CYC
  // clocks after the press was acted on if the level has stayed high.
  initial forever begin
    @(posedge clk100 or posedge rst);
    if (rst) begin
      mDiv      = DIV_INIT;
      mWren     = 1'b0;
      mDb       = 1'b0;
      hist.delete();
      mRun      = 0;
      mEnter    = 0;
      mInPress  = 1'b0;
      mLongDone = 1'b0;
    end else begin
      int  n;
      logic s;
      logic prevDb;
      hist.push_back(btn_i);
      n      = hist.size() - 1;
      prevDb = mDb;
      mWren  = 1'b0;
      if (!mInPress) begin
        if (prevDb) begin
          mDiv      = (mDiv == DIV_MAX) ? 5'd0 : mDiv + 5'd1;
          mWren     = 1'b1;
          mInPress  = 1'b1;
          mLongDone = 1'b0;
          mEnter    = n;
        end
      end else if (!prevDb) begin
        mInPress = 1'b0;
      end
`ifdef LED_DIV_LONGPRESS_EN
      else if (!mLongDone && (n - mEnter == LONG_CYC)) begin
        mDiv      = DIV_INIT;
        mWren     = 1'b1;
        mLongDone = 1'b1;
      end
`endif
      s = (n >= 2) ? hist[n-2] : 1'b0;
      if (s != mDb) mRun++;
      else mRun = 0;
      if (mRun == DB_CYC + 1) begin
        mDb  = s;
        mRun = 0;
      end
    end
  end

  // Async reset asserted mid-cycle, held, then released.
  task automatic test_reset();
    rst   = 1'b1;
    btn_i = 1'b0;
    repeat (3) begin
      @(negedge clk100);
      checks++;
      if ({div_o, wren_o, btn_db_o} !== {DIV_INIT, 1'b0, 1'b0})
        begin errors++; $display("[TB] FAIL reset_hold: got div=%0d wren=%0b db=%0b, expected div=%0d wren=0 db=0", div_o, wren_o, btn_db_o, DIV_INIT); end
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk100);
      checks++;
      if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
        begin errors++; $display("[TB] FAIL reset_release: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
    end
    @(posedge clk100);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({div_o, wren_o, btn_db_o} !== {DIV_INIT, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL reset_async: got div=%0d wren=%0b db=%0b, expected div=%0d wren=0 db=0", div_o, wren_o, btn_db_o, DIV_INIT); end
    repeat (2) @(negedge clk100);
    rst = 1'b0;
  endtask

  // One clean press with exact latency checks, then a release.
  task automatic test_clean_press();
    int pulses = 0;
    @(negedge clk100);
    btn_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk100);
      if (wren_o) pulses++;
      checks++;
      if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
        begin errors++; $display("[TB] FAIL press_model c=%0d: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", c, div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
      checks++;
      if ({wren_o, btn_db_o} !== {(c == 7), (c >= 6)})
        begin errors++; $display("[TB] FAIL press_latency c=%0d: got wren=%0b db=%0b, expected wren=%0b db=%0b", c, wren_o, btn_db_o, (c == 7), (c >= 6)); end
    end
    checks++;
    if (div_o !== 5'd3 || pulses != 1)
      begin errors++; $display("[TB] FAIL press_result: got div=%0d pulses=%0d, expected div=3 pulses=1", div_o, pulses); end
    btn_i  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk100);
      if (wren_o) pulses++;
      checks++;
      if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
        begin errors++; $display("[TB] FAIL release_model c=%0d: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", c, div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
    end
    checks++;
    if (div_o !== 5'd3 || pulses != 0 || btn_db_o !== 1'b0)
      begin errors++; $display("[TB] FAIL release_result: got div=%0d pulses=%0d db=%0b, expected div=3 pulses=0 db=0", div_o, pulses, btn_db_o); end
  endtask

  // Short random pulses never pass the debouncer; the same chatter followed
  // by a steady high gives exactly one strobe.
  task automatic test_bounce();
    int   pulses = 0;
    int   dbHigh = 0;
    logic lvl;
    for (int phase = 0; phase < 2; phase++) begin
      int cyc = 0;
      lvl = 1'b0;
      pulses = 0;
      while (cyc < 30) begin
        int len = $urandom_range(1, 3);
        lvl   = ~lvl;
        btn_i = lvl;
        repeat (len) begin
          @(negedge clk100);
          cyc++;
          if (wren_o) pulses++;
          if (btn_db_o) dbHigh++;
          checks++;
          if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
            begin errors++; $display("[TB] FAIL bounce_model: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
        end
      end
      btn_i = (phase == 1);
      repeat (12) begin
        @(negedge clk100);
        if (wren_o) pulses++;
        if (btn_db_o && phase == 0) dbHigh++;
        checks++;
        if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
          begin errors++; $display("[TB] FAIL bounce_settle: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
      end
      if (phase == 0) begin
        checks++;
        if (pulses != 0 || dbHigh != 0)
          begin errors++; $display("[TB] FAIL bounce_reject: got pulses=%0d dbHighCycles=%0d, expected 0 and 0", pulses, dbHigh); end
      end else begin
        checks++;
        if (pulses != 1)
          begin errors++; $display("[TB] FAIL bounce_then_hold: got pulses=%0d, expected 1", pulses); end
      end
    end
    btn_i = 1'b0;
    repeat (12) @(negedge clk100);
  endtask

  // Thirty spaced presses from reset walk the divider through the wrap.
  task automatic test_wrap();
    int pulses = 0;
    @(negedge clk100) rst = 1'b1;
    @(negedge clk100) rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      int expV = int'(DIV_INIT) + i;
      if (expV > int'(DIV_MAX)) expV = expV - (int'(DIV_MAX) + 1);
      for (int c = 0; c < 16; c++) begin
        btn_i = (c < 8);
        @(negedge clk100);
        if (wren_o) pulses++;
        checks++;
        if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
          begin errors++; $display("[TB] FAIL wrap_model i=%0d c=%0d: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", i, c, div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
      end
      checks++;
      if (div_o !== 5'(expV))
        begin errors++; $display("[TB] FAIL wrap_step i=%0d: got div=%0d, expected %0d", i, div_o, expV); end
    end
    checks++;
    if (pulses != 30 || div_o !== 5'd0)
      begin errors++; $display("[TB] FAIL wrap_total: got pulses=%0d div=%0d, expected 30 and 0", pulses, div_o); end
  endtask

  // Long hold starting from divider 5.
  task automatic test_long_press();
    int         pulses = 0;
    logic [4:0] d1 = '0;
    logic [4:0] d2 = '0;
    @(negedge clk100) rst = 1'b1;
    @(negedge clk100) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 16; c++) begin
        btn_i = (c < 8);
        @(negedge clk100);
        checks++;
        if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
          begin errors++; $display("[TB] FAIL long_setup: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
      end
    end
    checks++;
    if (div_o !== 5'd5)
      begin errors++; $display("[TB] FAIL long_start: got div=%0d, expected 5", div_o); end
    btn_i = 1'b1;
    for (int c = 0; c < 47; c++) begin
      @(negedge clk100);
      if (wren_o) begin
        pulses++;
        if (pulses == 1) d1 = div_o;
        else if (pulses == 2) d2 = div_o;
      end
      checks++;
      if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
        begin errors++; $display("[TB] FAIL long_model c=%0d: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", c, div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
    end
`ifdef LED_DIV_LONGPRESS_EN
    checks++;
    if (pulses != 2 || d1 !== 5'd6 || d2 !== DIV_INIT || div_o !== DIV_INIT)
      begin errors++; $display("[TB] FAIL long_result: got pulses=%0d first=%0d second=%0d div=%0d, expected 2, 6, 2, 2", pulses, d1, d2, div_o); end
`else
    checks++;
    if (pulses != 1 || d1 !== 5'd6 || div_o !== 5'd6)
      begin errors++; $display("[TB] FAIL long_result: got pulses=%0d first=%0d second=%0d div=%0d, expected 1, 6, -, 6", pulses, d1, d2, div_o); end
`endif
    btn_i  = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk100);
      if (wren_o) pulses++;
    end
    checks++;
    if (pulses != 0 || btn_db_o !== 1'b0)
      begin errors++; $display("[TB] FAIL long_release: got pulses=%0d db=%0b, expected 0 and 0", pulses, btn_db_o); end
  endtask

  // Reset while held; the still-held button counts as a fresh press.
  task automatic test_reset_hold();
    int pulses  = 0;
    int firstAt = -1;
    @(negedge clk100) rst = 1'b1;
    @(negedge clk100) rst = 1'b0;
    btn_i = 1'b1;
    repeat (10) @(negedge clk100);
    checks++;
    if (div_o !== 5'd3 || btn_db_o !== 1'b1)
      begin errors++; $display("[TB] FAIL hold_before_reset: got div=%0d db=%0b, expected 3 and 1", div_o, btn_db_o); end
    @(posedge clk100);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({div_o, wren_o, btn_db_o} !== {DIV_INIT, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL hold_reset_async: got div=%0d wren=%0b db=%0b, expected div=%0d wren=0 db=0", div_o, wren_o, btn_db_o, DIV_INIT); end
    repeat (3) @(negedge clk100);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk100);
      if (wren_o) begin
        pulses++;
        if (firstAt < 0) firstAt = c;
      end
      checks++;
      if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
        begin errors++; $display("[TB] FAIL hold_model c=%0d: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", c, div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
    end
    checks++;
    if (firstAt < 0)
      begin errors++; $display("[TB] FAIL hold_timeout: no strobe within 12 cycles of reset release, expected one"); end
    else if (firstAt < 6 || firstAt > 7 || pulses != 1 || div_o !== 5'd3)
      begin errors++; $display("[TB] FAIL hold_fresh_press: got firstAt=%0d pulses=%0d div=%0d, expected 6..7, 1, 3", firstAt, pulses, div_o); end
    btn_i = 1'b0;
    repeat (12) @(negedge clk100);
  endtask

  // Random segments of steady levels, short and long, back to back.
  task automatic test_random();
    for (int s = 0; s < 30; s++) begin
      int len = $urandom_range(1, 40);
      btn_i = 1'($urandom_range(0, 1));
      repeat (len) begin
        @(negedge clk100);
        checks++;
        if ({div_o, wren_o, btn_db_o} !== {mDiv, mWren, mDb})
          begin errors++; $display("[TB] FAIL random_model seg=%0d: got div=%0d wren=%0b db=%0b, expected div=%0d wren=%0b db=%0b", s, div_o, wren_o, btn_db_o, mDiv, mWren, mDb); end
      end
    end
    btn_i = 1'b0;
  endtask

  initial begin
    $display("[TB] starting led_div_ctrl bench");
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_long_press();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
